// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, ALU case
// selectors, ALU operation codes and trap causes.
package mc_pkg;

    typedef enum logic [4:0] {
        StIf       = 5'd0,
        StId       = 5'd1,
        StMemAddr  = 5'd2,
        StLwAcc    = 5'd3,
        StLwWb     = 5'd4,
        StSwAcc    = 5'd5,
        StRExec    = 5'd6,
        StRWb      = 5'd7,
        StBeq      = 5'd8,
        StBne      = 5'd9,
        StJ        = 5'd10,
        StJr       = 5'd11,
        StJal      = 5'd12,
        StAddiExec = 5'd13,
        StAndiExec = 5'd14,
        StImmWb    = 5'd15,
        StTrap     = 5'd16
    } state_e;

    typedef enum logic [1:0] {
        AluCaseAdd  = 2'b00,
        AluCaseSub  = 2'b01,
        AluCaseFunc = 2'b10,
        AluCaseAnd  = 2'b11
    } alu_case_e;

    typedef enum logic [1:0] {
        TrapNone    = 2'b00,
        TrapIllegal = 2'b01,
        TrapTimeout = 2'b10
    } trap_cause_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpJr    = 6'b000001;

    localparam logic [5:0] FuncAdd = 6'b100000;
    localparam logic [5:0] FuncSub = 6'b100010;
    localparam logic [5:0] FuncAnd = 6'b100100;
    localparam logic [5:0] FuncOr  = 6'b100101;
    localparam logic [5:0] FuncSlt = 6'b101010;

    localparam logic [2:0] AluOpAnd = 3'b000;
    localparam logic [2:0] AluOpOr  = 3'b001;
    localparam logic [2:0] AluOpAdd = 3'b010;
    localparam logic [2:0] AluOpSub = 3'b110;
    localparam logic [2:0] AluOpSlt = 3'b111;

endpackage

// File: rtl/mc_controller_alu_ctrl.sv
// ALU operation decoder: maps the FSM's ALU case and the R-type function field
// onto the 3-bit ALU operation code.
module ALU_Controller
    import mc_pkg::*;
(
    input  logic [5:0] func_i,
    input  alu_case_e  alu_case_i,
    output logic [2:0] alu_op_o
);

    always_comb begin
        alu_op_o = AluOpAdd;
        unique case (alu_case_i)
            AluCaseAdd: alu_op_o = AluOpAdd;
            AluCaseSub: alu_op_o = AluOpSub;
            AluCaseAnd: alu_op_o = AluOpAnd;
            AluCaseFunc: begin
                case (func_i)
                    FuncAdd: alu_op_o = AluOpAdd;
                    FuncSub: alu_op_o = AluOpSub;
                    FuncAnd: alu_op_o = AluOpAnd;
                    FuncOr:  alu_op_o = AluOpOr;
                    FuncSlt: alu_op_o = AluOpSlt;
                    default: alu_op_o = AluOpAdd;
                endcase
            end
            default: alu_op_o = AluOpAdd;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM with memory wait-state timeout, sticky
// trap reporting and a retired-instruction counter.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned TIMEOUT_W     = 4,
    parameter int unsigned RETIRE_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                IorD,
    output logic                IR_write,
    output logic                ALU_srcA,
    output logic                reg_write,
    output logic                pc_write_input,
    output logic [1:0]          reg_dst,
    output logic [1:0]          pc_src,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          ALU_srcB,
    output logic [2:0]          alu_op,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic                retire,
    output logic [RETIRE_W-1:0] retired_cnt
);

    // Last count value before the limit 2**TIMEOUT_W-1 would be reached.
    localparam logic [TIMEOUT_W-1:0] WaitLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [RETIRE_W-1:0]  retired_q, retired_d;
    logic                 trap_q, trap_d;
    trap_cause_e          trap_cause_q, trap_cause_d;

    logic      ready_eff, mem_state, timeout, strobe_en;
    logic      mem_write_m, ir_write_m, reg_write_m, pc_write_m, retire_m;
    logic      beq_cond, bne_cond;
    alu_case_e alu_case;

    assign ready_eff = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign mem_state = (state_q == StIf) || (state_q == StLwAcc) || (state_q == StSwAcc);
    assign timeout   = mem_state && !ready_eff && (wait_q == WaitLast);
    assign strobe_en = rst && !timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIf;
            wait_q       <= '0;
            retired_q    <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= TrapNone;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            retired_q    <= retired_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIf: begin
                if (timeout)        state_d = StTrap;
                else if (ready_eff) state_d = StId;
            end
            StId: begin
                case (opcode)
                    OpRType: state_d = StRExec;
                    OpAddi:  state_d = StAddiExec;
                    OpAndi:  state_d = StAndiExec;
                    OpLw:    state_d = StMemAddr;
                    OpSw:    state_d = StMemAddr;
                    OpBeq:   state_d = StBeq;
                    OpBne:   state_d = StBne;
                    OpJ:     state_d = StJ;
                    OpJal:   state_d = StJal;
                    OpJr:    state_d = StJr;
                    default: state_d = StTrap;
                endcase
            end
            StMemAddr: state_d = (opcode == OpSw) ? StSwAcc : StLwAcc;
            StLwAcc: begin
                if (timeout)        state_d = StTrap;
                else if (ready_eff) state_d = StLwWb;
            end
            StSwAcc: begin
                if (timeout)        state_d = StTrap;
                else if (ready_eff) state_d = StIf;
            end
            StRExec:                state_d = StRWb;
            StAddiExec, StAndiExec: state_d = StImmWb;
            StLwWb, StRWb, StImmWb, StBeq, StBne, StJ, StJr, StJal: state_d = StIf;
            StTrap:                 state_d = StTrap;
            default:                state_d = StTrap;
        endcase

        if (state_d != state_q)            wait_d = '0;
        else if (mem_state && !ready_eff) wait_d = wait_q + TIMEOUT_W'(1);
        else                               wait_d = wait_q;

        // Cause is latched only on the first entry into TRAP.
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        if (state_d == StTrap && !trap_q) begin
            trap_d       = 1'b1;
            trap_cause_d = timeout ? TrapTimeout : TrapIllegal;
        end

        retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;
    end

    always_comb begin
        mem_read    = 1'b0;
        IorD        = 1'b0;
        ALU_srcA    = 1'b0;
        reg_dst     = 2'b00;
        pc_src      = 2'b00;
        mem_to_reg  = 2'b00;
        ALU_srcB    = 2'b00;
        alu_case    = AluCaseAdd;
        mem_write_m = 1'b0;
        ir_write_m  = 1'b0;
        reg_write_m = 1'b0;
        pc_write_m  = 1'b0;
        retire_m    = 1'b0;
        beq_cond    = 1'b0;
        bne_cond    = 1'b0;
        unique case (state_q)
            StIf: begin
                mem_read   = 1'b1;
                ALU_srcB   = 2'b01;
                ir_write_m = ready_eff;
                pc_write_m = ready_eff;
            end
            StId:      ALU_srcB = 2'b11;
            StMemAddr: begin
                ALU_srcA = 1'b1;
                ALU_srcB = 2'b10;
            end
            StLwAcc: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
            end
            StLwWb: begin
                reg_write_m = 1'b1;
                mem_to_reg  = 2'b01;
                retire_m    = 1'b1;
            end
            StSwAcc: begin
                mem_write_m = 1'b1;
                IorD        = 1'b1;
                retire_m    = ready_eff;
            end
            StRExec: begin
                ALU_srcA = 1'b1;
                alu_case = AluCaseFunc;
            end
            StRWb: begin
                reg_write_m = 1'b1;
                reg_dst     = 2'b01;
                retire_m    = 1'b1;
            end
            StAddiExec, StAndiExec: begin
                ALU_srcA = 1'b1;
                ALU_srcB = 2'b10;
                alu_case = (state_q == StAndiExec) ? AluCaseAnd : AluCaseAdd;
            end
            StImmWb: begin
                reg_write_m = 1'b1;
                retire_m    = 1'b1;
            end
            StBeq, StBne: begin
                ALU_srcA = 1'b1;
                alu_case = AluCaseSub;
                pc_src   = 2'b10;
                beq_cond = (state_q == StBeq);
                bne_cond = (state_q == StBne);
                retire_m = 1'b1;
            end
            StJ, StJr: begin
                pc_write_m = 1'b1;
                pc_src     = (state_q == StJr) ? 2'b11 : 2'b01;
                retire_m   = 1'b1;
            end
            StJal: begin
                reg_write_m = 1'b1;
                pc_write_m  = 1'b1;
                pc_src      = 2'b01;
                mem_to_reg  = 2'b10;
                reg_dst     = 2'b10;
                retire_m    = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_write      = mem_write_m & strobe_en;
    assign IR_write       = ir_write_m & strobe_en;
    assign reg_write      = reg_write_m & strobe_en;
    assign retire         = retire_m & strobe_en;
    assign pc_write_input = (pc_write_m | (beq_cond & zero) | (bne_cond & ~zero)) & strobe_en;
    assign trap           = trap_q;
    assign trap_cause     = trap_cause_q;
    assign retired_cnt    = retired_q;

    ALU_Controller u_alu_ctrl (
        .func_i     (func),
        .alu_case_i (alu_case),
        .alu_op_o   (alu_op)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a per-cycle vector table for the normal
// instruction flows plus hand sequences for trap and timeout behaviour.
module tb_mc_controller;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, func;
    logic        zero, mem_ready;
    logic        mem_read, mem_write, IorD, IR_write, ALU_srcA, reg_write, pc_write_input;
    logic [1:0]  reg_dst, pc_src, mem_to_reg, ALU_srcB, trap_cause;
    logic [2:0]  alu_op;
    logic        trap, retire;
    logic [15:0] retired_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_controller #(
        .MEM_HANDSHAKE (1'b1),
        .TIMEOUT_W     (4),
        .RETIRE_W      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .func           (func),
        .zero           (zero),
        .mem_ready      (mem_ready),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .IorD           (IorD),
        .IR_write       (IR_write),
        .ALU_srcA       (ALU_srcA),
        .reg_write      (reg_write),
        .pc_write_input (pc_write_input),
        .reg_dst        (reg_dst),
        .pc_src         (pc_src),
        .mem_to_reg     (mem_to_reg),
        .ALU_srcB       (ALU_srcB),
        .alu_op         (alu_op),
        .trap           (trap),
        .trap_cause     (trap_cause),
        .retire         (retire),
        .retired_cnt    (retired_cnt)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {mem_read, mem_write, IorD, IR_write, ALU_srcA, reg_write, pc_write_input,
    //  reg_dst, pc_src, mem_to_reg, ALU_srcB, alu_op, retire}
    function automatic logic [18:0] ex(input logic mr, mw, iord, irw, sa, rw, pcw,
                                       input logic [1:0] rd, ps, m2r, sb,
                                       input logic [2:0] aop, input logic ret);
        return {mr, mw, iord, irw, sa, rw, pcw, rd, ps, m2r, sb, aop, ret};
    endfunction

    function automatic logic [18:0] act_word();
        return {mem_read, mem_write, IorD, IR_write, ALU_srcA, reg_write, pc_write_input,
                reg_dst, pc_src, mem_to_reg, ALU_srcB, alu_op, retire};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [18:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [18:0] e_if_w, e_if_r, e_id, e_maddr, e_lwacc, e_lwwb, e_sw_w, e_sw_r, e_sw_rst;
    logic [18:0] e_rwb, e_immwb, e_j, e_jr, e_jal, e_trap;
    logic [18:0] e_r_sub, e_r_slt, e_addi, e_andi, e_br_t, e_br_f;
    int          exp_cnt;

    initial begin
        e_if_w   = ex(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b010, 0);
        e_if_r   = ex(1,0,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b010, 0);
        e_id     = ex(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 3'b010, 0);
        e_maddr  = ex(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b10, 3'b010, 0);
        e_lwacc  = ex(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0);
        e_lwwb   = ex(0,0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b00, 3'b010, 1);
        e_sw_w   = ex(0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0);
        e_sw_r   = ex(0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b010, 1);
        e_sw_rst = ex(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0);
        e_r_sub  = ex(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b110, 0);
        e_r_slt  = ex(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b111, 0);
        e_rwb    = ex(0,0,0,0,0,1,0, 2'b01,2'b00,2'b00,2'b00, 3'b010, 1);
        e_addi   = ex(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b10, 3'b010, 0);
        e_andi   = ex(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b10, 3'b000, 0);
        e_immwb  = ex(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b010, 1);
        e_br_t   = ex(0,0,0,0,1,0,1, 2'b00,2'b10,2'b00,2'b00, 3'b110, 1);
        e_br_f   = ex(0,0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b110, 1);
        e_j      = ex(0,0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00, 3'b010, 1);
        e_jr     = ex(0,0,0,0,0,0,1, 2'b00,2'b11,2'b00,2'b00, 3'b010, 1);
        e_jal    = ex(0,0,0,0,0,1,1, 2'b10,2'b01,2'b10,2'b00, 3'b010, 1);
        e_trap   = ex(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0);

        // Reset held in IF: fetch strobes suppressed even with mem_ready high
        add(0, OpAddi, 6'd0, 0, 1, e_if_w);
        // ADDI, 4 cycles
        add(1, OpAddi, 6'd0, 0, 1, e_if_r);
        add(1, OpAddi, 6'd0, 0, 1, e_id);
        add(1, OpAddi, 6'd0, 0, 1, e_addi);
        add(1, OpAddi, 6'd0, 0, 1, e_immwb);
        // LW with three wait cycles in LW_ACC, 8 cycles
        add(1, OpLw, 6'd0, 0, 1, e_if_r);
        add(1, OpLw, 6'd0, 0, 1, e_id);
        add(1, OpLw, 6'd0, 0, 1, e_maddr);
        for (int k = 0; k < 3; k++) add(1, OpLw, 6'd0, 0, 0, e_lwacc);
        add(1, OpLw, 6'd0, 0, 1, e_lwacc);
        add(1, OpLw, 6'd0, 0, 1, e_lwwb);
        // R-type sub and slt
        add(1, OpRType, FuncSub, 0, 1, e_if_r);
        add(1, OpRType, FuncSub, 0, 1, e_id);
        add(1, OpRType, FuncSub, 0, 1, e_r_sub);
        add(1, OpRType, FuncSub, 0, 1, e_rwb);
        add(1, OpRType, FuncSlt, 0, 1, e_if_r);
        add(1, OpRType, FuncSlt, 0, 1, e_id);
        add(1, OpRType, FuncSlt, 0, 1, e_r_slt);
        add(1, OpRType, FuncSlt, 0, 1, e_rwb);
        // ANDI
        add(1, OpAndi, 6'd0, 0, 1, e_if_r);
        add(1, OpAndi, 6'd0, 0, 1, e_id);
        add(1, OpAndi, 6'd0, 0, 1, e_andi);
        add(1, OpAndi, 6'd0, 0, 1, e_immwb);
        // Branches with both zero-flag values
        add(1, OpBeq, 6'd0, 1, 1, e_if_r); add(1, OpBeq, 6'd0, 1, 1, e_id);
        add(1, OpBeq, 6'd0, 1, 1, e_br_t);
        add(1, OpBeq, 6'd0, 0, 1, e_if_r); add(1, OpBeq, 6'd0, 0, 1, e_id);
        add(1, OpBeq, 6'd0, 0, 1, e_br_f);
        add(1, OpBne, 6'd0, 1, 1, e_if_r); add(1, OpBne, 6'd0, 1, 1, e_id);
        add(1, OpBne, 6'd0, 1, 1, e_br_f);
        add(1, OpBne, 6'd0, 0, 1, e_if_r); add(1, OpBne, 6'd0, 0, 1, e_id);
        add(1, OpBne, 6'd0, 0, 1, e_br_t);
        // Jumps
        add(1, OpJ,   6'd0, 0, 1, e_if_r); add(1, OpJ,   6'd0, 0, 1, e_id);
        add(1, OpJ,   6'd0, 0, 1, e_j);
        add(1, OpJr,  6'd0, 0, 1, e_if_r); add(1, OpJr,  6'd0, 0, 1, e_id);
        add(1, OpJr,  6'd0, 0, 1, e_jr);
        add(1, OpJal, 6'd0, 0, 1, e_if_r); add(1, OpJal, 6'd0, 0, 1, e_id);
        add(1, OpJal, 6'd0, 0, 1, e_jal);
        // SW with one fetch wait and one store wait
        add(1, OpSw, 6'd0, 0, 0, e_if_w);
        add(1, OpSw, 6'd0, 0, 1, e_if_r);
        add(1, OpSw, 6'd0, 0, 1, e_id);
        add(1, OpSw, 6'd0, 0, 1, e_maddr);
        add(1, OpSw, 6'd0, 0, 0, e_sw_w);
        add(1, OpSw, 6'd0, 0, 1, e_sw_r);
        // SW abandoned by reset in SW_ACC; counter cleared, back in IF
        add(1, OpSw, 6'd0, 0, 1, e_if_r);
        add(1, OpSw, 6'd0, 0, 1, e_id);
        add(1, OpSw, 6'd0, 0, 1, e_maddr);
        add(0, OpSw, 6'd0, 0, 1, e_sw_rst);
        add(1, OpAddi, 6'd0, 0, 1, e_if_r);

        rst = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        exp_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; opcode = vecs[i].op; func = vecs[i].fn;
            zero = vecs[i].z; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d ctrl", i), 32'(act_word()), 32'(vecs[i].exp));
            chk($sformatf("vec%0d trap", i), {29'd0, trap, trap_cause}, 32'd0);
            chk($sformatf("vec%0d retired_cnt", i), 32'(retired_cnt), 32'(exp_cnt));
            exp_cnt = !vecs[i].rst ? 0 : exp_cnt + int'(vecs[i].exp[0]);
        end

        // Illegal opcode: TRAP the cycle after ID, no strobes while held
        reset_dut();
        opcode = 6'b111111; mem_ready = 1'b1; zero = 1'b1;
        @(negedge clk);
        #1 chk("illegal id ctrl", 32'(act_word()), 32'(e_id));
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            mem_ready = k[0];
            #1;
            chk("illegal trap ctrl", 32'(act_word()), 32'(e_trap));
            chk("illegal trap flag", {31'd0, trap}, 32'd1);
            chk("illegal trap_cause", {30'd0, trap_cause}, 32'd1);
            @(negedge clk);
        end
        chk("illegal retired_cnt", 32'(retired_cnt), 32'd0);

        // Fetch timeout: 15 waiting cycles in IF, then TRAP with cause 10
        reset_dut();
        mem_ready = 1'b0; opcode = OpAddi;
        for (int k = 1; k <= 15; k++) begin
            #1;
            chk($sformatf("if_to c%0d mem_read", k), {31'd0, mem_read}, 32'd1);
            chk($sformatf("if_to c%0d IR_write", k), {31'd0, IR_write}, 32'd0);
            chk($sformatf("if_to c%0d trap", k), {31'd0, trap}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("if_to trap", {31'd0, trap}, 32'd1);
        chk("if_to trap_cause", {30'd0, trap_cause}, 32'd2);
        chk("if_to ctrl", 32'(act_word()), 32'(e_trap));

        // Store timeout: mem_write dropped on the timeout cycle itself
        reset_dut();
        opcode = OpSw; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 15; k++) begin
            #1;
            chk($sformatf("sw_to c%0d mem_write", k), {31'd0, mem_write},
                (k < 15) ? 32'd1 : 32'd0);
            chk($sformatf("sw_to c%0d retire", k), {31'd0, retire}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("sw_to trap_cause", {29'd0, trap, trap_cause}, 32'b110);
        chk("sw_to retired_cnt", 32'(retired_cnt), 32'd0);

        // Trap persists until reset, then clears
        @(negedge clk);
        mem_ready = 1'b1;
        #1 chk("trap held", {29'd0, trap, trap_cause}, 32'b110);
        reset_dut();
        #1;
        chk("trap cleared", {29'd0, trap, trap_cause}, 32'd0);
        chk("post reset ctrl", 32'(act_word()), 32'(e_if_w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
